// File: rtl/vga_linebuf_fetch.sv
// Pixel source for the VGA controller: 2x-upscaled framebuffer through ping-pong line buffers.
// Pixel is combinational; a row fill takes SRC_W+1 cycles; a fill still running at the next swap/vsync is aborted and flags underrun.
module vga_linebuf_fetch #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  output logic [11:0]       pixel,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [11:0]       fb_data,
  output logic              busy,
  output logic              underrun
);

  localparam int COL_W = $clog2(SRC_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_d;
  logic              wr_en;
  logic              rd_sel;
  logic              pre;
  logic              vs_d;
  logic [11:0]       lb [2][SRC_W];

  logic              req_valid;
  logic              vs_rise;
  logic              swap;
  logic              evt;
  logic              pre_done;
  logic              start;
  logic [9:0]        x_half;
  logic [10:0]       next_row;
  logic [10:0]       start_row;
  logic [ADDR_W-1:0] start_addr;

  assign req_valid = (pix_x != 10'h3FF) && (pix_y != 10'h3FF);
  assign x_half    = pix_x >> 1;
  assign vs_rise   = vs && !vs_d;
  assign swap      = req_valid && (pix_x == 10'(2*SRC_W-1)) && pix_y[0];
  assign evt       = vs_rise || swap;
  assign next_row  = ((11'(pix_y) + 11'd1) >> 1) + 11'd1;
  assign busy      = (state != IDLE);
  assign fb_rd_en  = (state == FILL);
  assign pre_done  = (state == DRAIN) && pre && !evt;

  always_comb begin
    pixel = 12'h000;
    if (req_valid && (x_half < 10'(SRC_W)))
      pixel = lb[rd_sel][x_half[COL_W-1:0]];
  end

  // vsync outranks a same-cycle swap; the prefetch chain fetches row 1 straight after row 0
  always_comb begin
    start     = 1'b0;
    start_row = 11'd0;
    if (vs_rise) begin
      start     = 1'b1;
      start_row = 11'd0;
    end else if (swap && (next_row < 11'(SRC_H))) begin
      start     = 1'b1;
      start_row = next_row;
    end else if (pre_done) begin
      start     = 1'b1;
      start_row = 11'd1;
    end
  end

  assign start_addr = ADDR_W'(start_row) * ADDR_W'(SRC_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      col_d    <= '0;
      wr_en    <= 1'b0;
      fb_addr  <= '0;
      rd_sel   <= 1'b0;
      pre      <= 1'b0;
      vs_d     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      vs_d  <= vs;
      col_d <= col;
      // a read issued in the cycle of an abort is never written
      wr_en <= (state == FILL) && !evt;

      if (evt && busy)
        underrun <= 1'b1;

      if (vs_rise)
        pre <= 1'b1;
      else if (swap || pre_done)
        pre <= 1'b0;

      if ((swap && !vs_rise) || pre_done)
        rd_sel <= ~rd_sel;

      if (start) begin
        state   <= FILL;
        col     <= '0;
        fb_addr <= start_addr;
      end else if (evt) begin
        state <= IDLE;
        col   <= '0;
      end else begin
        case (state)
          FILL: begin
            col <= col + COL_W'(1);
            if (col == COL_W'(SRC_W-1))
              state <= DRAIN;
            else
              fb_addr <= fb_addr + ADDR_W'(1);
          end
          DRAIN:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Data lands one cycle after its read, into the buffer not on display
  always_ff @(posedge clk) begin
    if (wr_en && !rst && !evt)
      lb[~rd_sel][col_d] <= fb_data;
  end

endmodule

// File: tb/tb_vga_linebuf_fetch.sv
// Bench for vga_linebuf_fetch: framebuffer RAM model, pixel lookup table, random-content display sweep
// and hand-written sequences for overrun, vsync/swap collision, mid-fill reset and end of frame.
module tb_vga_linebuf_fetch;

  localparam int SRC_W  = 320;
  localparam int SRC_H  = 240;
  localparam int ADDR_W = 17;
  localparam int FB_N   = SRC_W * SRC_H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vs = 1'b0;
  logic [9:0]        pix_x = 10'h3FF;
  logic [9:0]        pix_y = 10'h3FF;
  logic [11:0]       pixel;
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  logic [11:0]       fb_data;
  logic              busy;
  logic              underrun;

  logic [11:0] fb_mem [FB_N];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] exp_pixel;
  } vec_t;

  vec_t tbl[10];

  vga_linebuf_fetch #(.SRC_W(SRC_W), .SRC_H(SRC_H), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .vs       (vs),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pixel    (pixel),
    .fb_rd_en (fb_rd_en),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // synchronous-read framebuffer, one cycle latency
  always @(posedge clk) begin
    if (fb_rd_en)
      fb_data <= fb_mem[fb_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y);
    pix_x = x;
    pix_y = y;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vs  = 1'b0;
    set_pix(10'h3FF, 10'h3FF);
    ticks(3);
    rst = 1'b0;
  endtask

  function automatic logic [11:0] fb_pat(input int mode, input int a);
    if (mode == 1) return ~12'(a);
    return 12'(a);
  endfunction

  task automatic fill_fb(input int mode);
    for (int i = 0; i < FB_N; i++)
      fb_mem[17'(i)] = (mode == 2) ? 12'($urandom) : fb_pat(mode, i);
  endtask

  // leaves the bench in the first FILL cycle of the row-0 prefetch
  task automatic vs_pulse();
    vs = 1'b1;
    tick();
    vs = 1'b0;
  endtask

  initial begin
    logic              exp_rd;
    int                n;
    int                blank;
    logic [ADDR_W-1:0] max_addr;
    logic              seen;

    tbl[0] = '{10'd0,   10'd0,   12'd0};
    tbl[1] = '{10'd1,   10'd0,   12'd0};
    tbl[2] = '{10'd2,   10'd0,   12'd1};
    tbl[3] = '{10'd5,   10'd0,   12'd2};
    tbl[4] = '{10'd100, 10'd0,   12'd50};
    tbl[5] = '{10'd638, 10'd0,   12'd319};
    tbl[6] = '{10'd639, 10'd0,   12'd319};
    tbl[7] = '{10'd400, 10'd2,   12'd200};
    tbl[8] = '{10'h3FF, 10'd0,   12'd0};
    tbl[9] = '{10'd5,   10'h3FF, 12'd0};

    // reset state
    fill_fb(0);
    do_reset();
    chk("reset_pixel",    32'(pixel),    32'h000);
    chk("reset_busy",     32'(busy),     32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    chk("reset_rd_en",    32'(fb_rd_en), 32'd0);
    chk("reset_addr",     32'(fb_addr),  32'd0);

    // frame prefetch: row 0 then row 1, back to back
    vs_pulse();
    for (int k = 0; k < 700; k++) begin
      exp_rd = (k < SRC_W) || ((k >= SRC_W + 1) && (k < 2*SRC_W + 1));
      chk("prefetch_rd_en", 32'(fb_rd_en), 32'(exp_rd));
      if (exp_rd)
        chk("prefetch_addr", 32'(fb_addr), (k < SRC_W) ? 32'(k) : 32'(k - 1));
      chk("prefetch_busy", 32'(busy), 32'(k < 2*SRC_W + 2));
      if (k == SRC_W + 1)
        chk("prefetch_rd_sel", 32'(dut.rd_sel), 32'd1);
      tick();
    end
    chk("prefetch_underrun", 32'(underrun), 32'd0);

    for (int i = 0; i < 10; i++) begin
      set_pix(tbl[i].x, tbl[i].y);
      chk("table_pixel", 32'(pixel), 32'(tbl[i].exp_pixel));
    end
    set_pix(10'h3FF, 10'h3FF);

    // random framebuffer, displayed through a VGA-like sweep with random horizontal blanking
    do_reset();
    fill_fb(2);
    vs = 1'b1;
    ticks(3);
    vs = 1'b0;
    ticks(700);
    for (int y = 0; y < 24; y++) begin
      blank = $urandom_range(10, 160);
      for (int h = 0; h < 640 + blank; h++) begin
        if (h < 640) begin
          set_pix(10'(h), 10'(y));
          chk("frame_pixel", 32'(pixel), 32'(fb_mem[17'((y >> 1) * SRC_W + (h >> 1))]));
        end else begin
          set_pix(10'h3FF, 10'h3FF);
        end
        tick();
      end
      chk("frame_underrun", 32'(underrun), 32'd0);
    end
    set_pix(10'h3FF, 10'h3FF);

    // swap forced 100 cycles into the row-0 prefetch
    do_reset();
    fill_fb(0);
    vs_pulse();
    ticks(100);
    chk("ovr_pre_addr", 32'(fb_addr), 32'd100);
    set_pix(10'd639, 10'd1);
    tick();
    set_pix(10'h3FF, 10'h3FF);
    chk("ovr_underrun", 32'(underrun),   32'd1);
    chk("ovr_rd_sel",   32'(dut.rd_sel), 32'd1);
    chk("ovr_rd_en",    32'(fb_rd_en),   32'd1);
    chk("ovr_addr",     32'(fb_addr),    32'(2 * SRC_W));
    n = 0;
    while (busy && n < 1000) begin
      n++;
      tick();
    end
    chk("ovr_busy_cycles", 32'(n), 32'(SRC_W + 1));
    chk("ovr_pre",         32'(dut.pre),  32'd0);
    chk("ovr_sticky",      32'(underrun), 32'd1);

    // vsync edge and swap together while idle
    do_reset();
    vs = 1'b1;
    set_pix(10'd639, 10'd1);
    tick();
    vs = 1'b0;
    set_pix(10'h3FF, 10'h3FF);
    chk("coll_addr",     32'(fb_addr),  32'd0);
    chk("coll_rd_en",    32'(fb_rd_en), 32'd1);
    chk("coll_pre",      32'(dut.pre),  32'd1);
    chk("coll_underrun", 32'(underrun), 32'd0);

    // reset in the middle of a fill: lb[0] holds row 1 of pattern 0, refill with pattern 1
    do_reset();
    fill_fb(0);
    vs_pulse();
    ticks(700);
    fill_fb(1);
    vs_pulse();
    ticks(150);
    chk("rst_col", 32'(fb_addr), 32'd150);
    rst = 1'b1;
    tick();
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_rd_en",    32'(fb_rd_en), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    ticks(2);
    set_pix(10'd300, 10'd0);
    chk("rst_no_write_150", 32'(pixel), 32'(fb_pat(0, SRC_W + 150)));
    set_pix(10'd296, 10'd0);
    chk("rst_written_148",  32'(pixel), 32'(fb_pat(1, 148)));
    set_pix(10'h3FF, 10'h3FF);

    // last source row and the swap after it
    do_reset();
    fill_fb(0);
    set_pix(10'd639, 10'd475);
    tick();
    set_pix(10'h3FF, 10'h3FF);
    chk("last_row_addr",  32'(fb_addr),  32'((SRC_H - 1) * SRC_W));
    chk("last_row_rd_en", 32'(fb_rd_en), 32'd1);
    max_addr = '0;
    n = 0;
    while (busy && n < 1000) begin
      if (fb_rd_en && fb_addr > max_addr) max_addr = fb_addr;
      n++;
      tick();
    end
    chk("last_row_busy_cycles", 32'(n),        32'(SRC_W + 1));
    chk("last_row_max_addr",    32'(max_addr), 32'(FB_N - 1));
    set_pix(10'd639, 10'd477);
    tick();
    set_pix(10'h3FF, 10'h3FF);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (busy || fb_rd_en) seen = 1'b1;
      tick();
    end
    chk("end_frame_no_fill", 32'(seen),     32'd0);
    chk("end_frame_underrun", 32'(underrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
